program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Synthesizable replacement for bench-driven program loading.
- Accepts a valid/ready word stream containing an instruction section followed by a data section.
- Writes each section into the processor's instruction or data memory through the processor's new_instruction/add_into load interface, then asserts start_signal.
- Sits between a host/UART stream source and the processor; generalised in word width and memory depths, with overflow detection and optional manual start.

Parameters:
- WIDTH, 32, word width of in_data/new_instruction
- IMEM_DEPTH, 64, instruction memory words
- DMEM_DEPTH, 64, data memory words
- GAP_CYCLES, 1, idle cycles between sections and before start (1..15)
- AUTO_START, 1, 1: start after data section; 0: wait for run_req

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- load_req  in  1  begin load session (sampled in IDLE/ERROR only)
- run_req  in  1  start program when AUTO_START=0 (sampled in ARMED)
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts word
- in_data  in  WIDTH  stream word
- in_last  in  1  final word of current section
- new_instruction  out  WIDTH  word to processor memory
- add_into  out  1  0 instruction memory, 1 data memory
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  AW  AW = clog2(max(IMEM_DEPTH,DMEM_DEPTH))
- start_signal  out  1  processor run enable
- end_signal  in  1  processor halted (syscall exit)
- busy  out  1  high in any state except IDLE/ERROR
- error  out  1  section overflow, sticky
- instr_count  out  clog2(IMEM_DEPTH+1)  instruction words loaded
- data_count  out  clog2(DMEM_DEPTH+1)  data words loaded

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including counts, new_instruction and wr_addr.
  - Reset mid-load or mid-run aborts immediately: start_signal drops on the next edge and partially written memory is not cleared.
- Beat = in_valid & in_ready at a rising edge. All outputs are registered.
  - For a beat at edge k, new_instruction=in_data, wr_addr=section count before increment, and wr_en=1 during cycle k..k+1.
  - The count increments at edge k.
  - wr_en is low otherwise.
- in_ready = 1 only in LOAD_I and LOAD_D; it is combinational from state.
- States:
  - IDLE: load_req -> LOAD_I; counts cleared, add_into=0.
  - LOAD_I: each beat writes the instruction word.
    - Beat with in_last -> GAP1.
    - Beat with instr_count==IMEM_DEPTH -> ERROR; word dropped, no wr_en.
  - GAP1: hold GAP_CYCLES cycles (counter); add_into set to 1 on exit -> LOAD_D.
  - LOAD_D: same rules as LOAD_I against DMEM_DEPTH. Beat with in_last -> GAP2.
  - GAP2: hold GAP_CYCLES -> RUN if AUTO_START=1, else -> ARMED.
  - ARMED: run_req -> RUN.
  - RUN: start_signal=1 (level, asserted on entry edge). end_signal -> IDLE; start_signal deasserts on that edge. Counts and add_into are held until the next load_req.
  - ERROR: error=1, in_ready=0, start_signal=0. load_req clears error and -> LOAD_I.
- in_last on the first word of a section is legal (one-word section). Zero-length sections are not supported.
- Last allowed word (count==DEPTH-1) is written normally. Overflow triggers only on the DEPTH+1th word.
- Simultaneous events:
  - load_req in RUN is ignored.
  - end_signal outside RUN is ignored.
  - reset dominates everything.
- in_valid low stalls the current state with no timeout; in_data is ignored when not accepted.

Test Plan:
- Reset: pulse reset for 1 cycle mid-stream in LOAD_D -> next cycle state IDLE, all outputs 0, in_ready=0.
- Basic load, AUTO_START=1, GAP_CYCLES=1:
  - Stimulus: load_req, 3 instruction beats (0x20CD000A, 0x04CD000B, 0x5400_0000 with last), 2 data beats (15, 643 with last), all back-to-back.
  - Required: wr_en pulses with wr_addr 0,1,2 at add_into=0, then 0,1 at add_into=1.
  - Required: instr_count=3, data_count=2, start_signal=1 exactly 1+GAP_CYCLES cycles after the last data beat.
- Backpressure: toggle in_valid every other cycle over 4 instruction words -> exactly 4 wr_en pulses, addresses 0..3 contiguous, no duplicate writes.
- Overflow: IMEM_DEPTH=4, send 5 instruction words without in_last.
  - Required: 4 writes, then error=1, in_ready=0, no 5th wr_en.
  - Follow-up: load_req clears error and restarts at wr_addr 0.
- Manual start: AUTO_START=0, complete a load -> start_signal stays 0 for 20 cycles. run_req pulse -> start_signal=1 next edge.
- End of run: in RUN assert end_signal for 1 cycle -> start_signal=0 next edge, busy=0. A load_req asserted during RUN before end_signal is ignored (counts unchanged).

Source files
------------

// File: rtl/program_loader.sv
// program_loader: pulls an instruction section and then a data section from a
// valid/ready word stream. Each word is written into the processor's memories
// through the new_instruction/add_into/wr_en/wr_addr load port. The processor
// is then released with start_signal, either automatically or on run_req.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for load_req; counts and add_into hold their last values
// LOAD_I | accepting instruction words, add_into=0
// GAP1   | idle gap between sections; add_into flips to 1 on exit
// LOAD_D | accepting data words, add_into=1
// GAP2   | idle gap before the processor is started
// ARMED  | load complete, waiting for run_req (manual start only)
// RUN    | start_signal high until the processor reports end_signal
// ERROR  | a section overflowed its memory; sticky until the next load_req
module program_loader #(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int GAP_CYCLES = 1,
    parameter int AUTO_START = 1,
    localparam int MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH,
    localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
    localparam int ICW       = $clog2(IMEM_DEPTH + 1),
    localparam int DCW       = $clog2(DMEM_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic             run_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] new_instruction,
    output logic             add_into,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic             start_signal,
    input  logic             end_signal,
    output logic             busy,
    output logic             error,
    output logic [ICW-1:0]   instr_count,
    output logic [DCW-1:0]   data_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_GAP1,
        S_LOAD_D,
        S_GAP2,
        S_ARMED,
        S_RUN,
        S_ERROR
    } state_t;

    // The gap counter is loaded with GAP_CYCLES and the state is left once it
    // reaches zero, so start_signal rises 1+GAP_CYCLES edges after the last
    // data beat.
    localparam logic [3:0]     GAP_LOAD = 4'(GAP_CYCLES);
    localparam logic [ICW-1:0] I_FULL   = ICW'(IMEM_DEPTH);
    localparam logic [DCW-1:0] D_FULL   = DCW'(DMEM_DEPTH);

    state_t     state;
    logic [3:0] gap_cnt;
    logic       beat;

    // Ready and busy are decoded straight from the state register.
    always_comb begin
        in_ready = (state == S_LOAD_I) || (state == S_LOAD_D);
        busy     = !((state == S_IDLE) || (state == S_ERROR));
        beat     = in_valid && in_ready;
    end

    // Sequencer: section loading, gaps, start/stop and overflow detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            gap_cnt         <= '0;
            new_instruction <= '0;
            add_into        <= 1'b0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            start_signal    <= 1'b0;
            error           <= 1'b0;
            instr_count     <= '0;
            data_count      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (load_req) begin
                        state       <= S_LOAD_I;
                        instr_count <= '0;
                        data_count  <= '0;
                        add_into    <= 1'b0;
                        error       <= 1'b0;
                    end
                end
                S_LOAD_I: begin
                    if (beat) begin
                        if (instr_count == I_FULL) begin
                            // Overflowing word is dropped without a write.
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            new_instruction <= in_data;
                            wr_addr         <= AW'(instr_count);
                            wr_en           <= 1'b1;
                            instr_count     <= instr_count + ICW'(1);
                            if (in_last) begin
                                state   <= S_GAP1;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                end
                S_GAP1: begin
                    if (gap_cnt == 4'd0) begin
                        state    <= S_LOAD_D;
                        add_into <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_LOAD_D: begin
                    if (beat) begin
                        if (data_count == D_FULL) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            new_instruction <= in_data;
                            wr_addr         <= AW'(data_count);
                            wr_en           <= 1'b1;
                            data_count      <= data_count + DCW'(1);
                            if (in_last) begin
                                state   <= S_GAP2;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                end
                S_GAP2: begin
                    if (gap_cnt == 4'd0) begin
                        if (AUTO_START != 0) begin
                            state        <= S_RUN;
                            start_signal <= 1'b1;
                        end else begin
                            state <= S_ARMED;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_ARMED: begin
                    if (run_req) begin
                        state        <= S_RUN;
                        start_signal <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (end_signal) begin
                        state        <= S_IDLE;
                        start_signal <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: two loader instances share one stimulus driver.
// Instance A uses default sizes with auto start; instance B has 4-word
// memories, a 3-cycle gap and manual start. Writes are captured into queues
// and compared with the word lists the bench itself sent.
module tb_program_loader;

    localparam int GA = 1;
    localparam int GB = 3;
    localparam int DA = 64;
    localparam int DB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_req, run_req, in_valid, in_last, end_sig;
    logic [31:0] in_data;
    int          sel;

    logic        load_req_a, run_req_a, in_valid_a, end_sig_a;
    logic        load_req_b, run_req_b, in_valid_b, end_sig_b;
    assign load_req_a = load_req & (sel == 0);
    assign run_req_a  = run_req  & (sel == 0);
    assign in_valid_a = in_valid & (sel == 0);
    assign end_sig_a  = end_sig  & (sel == 0);
    assign load_req_b = load_req & (sel == 1);
    assign run_req_b  = run_req  & (sel == 1);
    assign in_valid_b = in_valid & (sel == 1);
    assign end_sig_b  = end_sig  & (sel == 1);

    logic        in_ready_a, add_into_a, wr_en_a, start_a, busy_a, error_a;
    logic [31:0] new_instr_a;
    logic [5:0]  wr_addr_a;
    logic [6:0]  icnt_a, dcnt_a;

    logic        in_ready_b, add_into_b, wr_en_b, start_b, busy_b, error_b;
    logic [31:0] new_instr_b;
    logic [1:0]  wr_addr_b;
    logic [2:0]  icnt_b, dcnt_b;

    program_loader #(.WIDTH(32), .IMEM_DEPTH(DA), .DMEM_DEPTH(DA),
                     .GAP_CYCLES(GA), .AUTO_START(1)) dut_a (
        .clk(clk), .reset(reset), .load_req(load_req_a), .run_req(run_req_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .in_last(in_last), .new_instruction(new_instr_a), .add_into(add_into_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .start_signal(start_a),
        .end_signal(end_sig_a), .busy(busy_a), .error(error_a),
        .instr_count(icnt_a), .data_count(dcnt_a));

    program_loader #(.WIDTH(32), .IMEM_DEPTH(DB), .DMEM_DEPTH(DB),
                     .GAP_CYCLES(GB), .AUTO_START(0)) dut_b (
        .clk(clk), .reset(reset), .load_req(load_req_b), .run_req(run_req_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .new_instruction(new_instr_b), .add_into(add_into_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .start_signal(start_b),
        .end_signal(end_sig_b), .busy(busy_b), .error(error_b),
        .instr_count(icnt_b), .data_count(dcnt_b));

    // Observed outputs of whichever instance is selected.
    logic        o_ready, o_add, o_wren, o_start, o_busy, o_error;
    logic [31:0] o_data;
    logic [7:0]  o_addr, o_icnt, o_dcnt;
    always_comb begin
        o_ready = (sel == 0) ? in_ready_a : in_ready_b;
        o_add   = (sel == 0) ? add_into_a : add_into_b;
        o_wren  = (sel == 0) ? wr_en_a    : wr_en_b;
        o_start = (sel == 0) ? start_a    : start_b;
        o_busy  = (sel == 0) ? busy_a     : busy_b;
        o_error = (sel == 0) ? error_a    : error_b;
        o_data  = (sel == 0) ? new_instr_a : new_instr_b;
        o_addr  = (sel == 0) ? 8'(wr_addr_a) : 8'(wr_addr_b);
        o_icnt  = (sel == 0) ? 8'(icnt_a) : 8'(icnt_b);
        o_dcnt  = (sel == 0) ? 8'(dcnt_a) : 8'(dcnt_b);
    end

    function automatic logic [63:0] pack(input logic a, input int addr, input logic [31:0] d);
        logic [7:0] a8;
        a8 = addr[7:0];
        return {23'd0, a, a8, d};
    endfunction

    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];
    always @(negedge clk) begin
        if (wr_en_a) wq_a.push_back(pack(add_into_a, int'(wr_addr_a), new_instr_a));
        if (wr_en_b) wq_b.push_back(pack(add_into_b, int'(wr_addr_b), new_instr_b));
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
        check({tag, "_wren"},  64'(o_wren),  64'd0);
        check({tag, "_start"}, 64'(o_start), 64'd0);
        check({tag, "_busy"},  64'(o_busy),  64'd0);
        check({tag, "_error"}, 64'(o_error), 64'd0);
        check({tag, "_add"},   64'(o_add),   64'd0);
        check({tag, "_data"},  64'(o_data),  64'd0);
        check({tag, "_addr"},  64'(o_addr),  64'd0);
        check({tag, "_icnt"},  64'(o_icnt),  64'd0);
        check({tag, "_dcnt"},  64'(o_dcnt),  64'd0);
    endtask

    // All driving happens at negedges; a beat occurs at the following posedge
    // when ready was high at the negedge.
    task automatic send_word(input logic [31:0] d, input logic last, input int idle);
        int  t;
        logic rdy;
        for (int i = 0; i < idle; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        forever begin
            rdy = o_ready;
            @(negedge clk);
            if (rdy) break;
            t++;
            if (t > 60) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    logic [31:0] sec_i[$];
    logic [31:0] sec_d[$];

    // One complete load session on the selected instance, with the expected
    // write list, counts and start behaviour derived from the section lists.
    task automatic session(input int max_idle, input bit toggle);
        int          depth, g, ni_w, nd_w, n;
        bit          err, seen_start;
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        depth = (sel == 0) ? DA : DB;
        g     = (sel == 0) ? GA : GB;
        if (sel == 0) wq_a.delete(); else wq_b.delete();
        err  = 0;
        ni_w = 0;
        nd_w = 0;
        pulse_load();
        check("load_err_clear", 64'(o_error), 64'd0);
        check("load_busy", 64'(o_busy), 64'd1);
        foreach (sec_i[i]) begin
            send_word(sec_i[i], i == sec_i.size() - 1,
                      toggle ? 1 : int'($urandom_range(0, max_idle)));
            if (i >= depth) begin
                err = 1;
                break;
            end
            exp_q.push_back(pack(1'b0, i, sec_i[i]));
            ni_w++;
        end
        if (!err) begin
            foreach (sec_d[i]) begin
                send_word(sec_d[i], i == sec_d.size() - 1,
                          toggle ? 1 : int'($urandom_range(0, max_idle)));
                if (i >= depth) begin
                    err = 1;
                    break;
                end
                exp_q.push_back(pack(1'b1, i, sec_d[i]));
                nd_w++;
            end
        end
        if (err) begin
            repeat (2) @(negedge clk);
            check("ovf_error", 64'(o_error), 64'd1);
            check("ovf_ready", 64'(o_ready), 64'd0);
            check("ovf_busy",  64'(o_busy),  64'd0);
            check("ovf_start", 64'(o_start), 64'd0);
        end else if (sel == 0) begin
            n = 0;
            while (!o_start && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("start_latency", 64'(n), 64'(1 + g));
        end else begin
            seen_start = 0;
            repeat (20) begin
                @(negedge clk);
                if (o_start) seen_start = 1;
            end
            check("manual_hold", 64'(seen_start), 64'd0);
            check("armed_busy", 64'(o_busy), 64'd1);
            run_req = 1'b1;
            @(negedge clk);
            run_req = 1'b0;
            check("manual_start", 64'(o_start), 64'd1);
        end
        got_q = (sel == 0) ? wq_a : wq_b;
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check("write", got_q[i], exp_q[i]);
        end
        check("instr_count", 64'(o_icnt), 64'(ni_w));
        check("data_count",  64'(o_dcnt), 64'(nd_w));
        if (!err) begin
            pulse_load();
            @(negedge clk);
            check("run_ignore_load_icnt", 64'(o_icnt), 64'(ni_w));
            check("run_ignore_load_start", 64'(o_start), 64'd1);
            end_sig = 1'b1;
            @(negedge clk);
            end_sig = 1'b0;
            check("end_start", 64'(o_start), 64'd0);
            check("end_busy",  64'(o_busy),  64'd0);
            check("end_hold_dcnt", 64'(o_dcnt), 64'(nd_w));
            check("end_hold_add",  64'(o_add),  64'd1);
        end
        @(negedge clk);
    endtask

    task automatic fill_random(input int ni, input int nd);
        sec_i.delete();
        sec_d.delete();
        for (int i = 0; i < ni; i++) sec_i.push_back($urandom);
        for (int i = 0; i < nd; i++) sec_d.push_back($urandom);
    endtask

    initial begin
        sel      = 0;
        reset    = 1'b1;
        load_req = 1'b0;
        run_req  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        end_sig  = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sel = 0;
        check_all_zero("rst_a");
        sel = 1;
        check_all_zero("rst_b");

        // Directed basic load on the auto-start instance.
        sel = 0;
        sec_i = '{32'h20CD000A, 32'h04CD000B, 32'h5400_0000};
        sec_d = '{32'd15, 32'd643};
        session(0, 0);

        // Valid toggling every other cycle over four instruction words.
        fill_random(4, 1);
        session(0, 1);

        for (int k = 0; k < 4; k++) begin
            fill_random(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
            session(3, 0);
        end

        // Reset in the middle of the data section.
        fill_random(3, 3);
        pulse_load();
        foreach (sec_i[i]) send_word(sec_i[i], i == 2, 0);
        send_word(sec_d[0], 1'b0, 3);
        in_valid = 1'b1;
        in_data  = sec_d[1];
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);

        // Overflow, restart and manual start on the small instance.
        sel = 1;
        fill_random(5, 1);
        session(0, 0);
        fill_random(2, 3);
        session(1, 0);

        for (int k = 0; k < 6; k++) begin
            fill_random(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            session(2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
